prbs_checker_multilane: RTL

Parametrised multi-lane, multi-polynomial PRBS checker for deserialised receive data in bit-alignment and link-training test paths. Each of NLANES lanes receives an NBITS-wide parallel word per enabled clock. Each lane self-synchronises to the selected PRBS sequence (PRBS7/15/23/31), tracks lock with a hysteresis state machine, and accumulates a saturating per-lane error-word count. A single registered summary flag lets training logic poll link quality.

---
 rtl/prbs_checker_multilane.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prbs_checker_multilane.sv
// Multi-lane self-synchronising PRBS7/15/23/31 checker with per-lane lock hysteresis,
// saturating per-lane error-word counters and a registered link-quality summary flag.
module prbs_checker_multilane #(
  parameter int NBITS       = 8,
  parameter int NLANES      = 4,
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        prbs_en_i,
  input  logic [1:0]                  poly_sel_i,
  input  logic [NLANES*NBITS-1:0]     data_in_i,
  input  logic                        err_clr_i,
  output logic [NLANES-1:0]           lane_err_o,
  output logic [NLANES-1:0]           lane_lock_o,
  output logic [NLANES*ERR_CNT_W-1:0] err_cnt_o,
  output logic                        prbs_chk_error_o
);

  localparam int SW = 31 + NBITS;
  localparam int CW = ERR_CNT_W;
  localparam logic [7:0]    LOCK_T  = 8'(LOCK_CNT);
  localparam logic [7:0]    LOSS_T  = 8'(LOSS_THRESH);
  localparam logic [SW-1:0] WMASK   = {{31{1'b0}}, {NBITS{1'b1}}};

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // s holds history above the new word; higher index = older bit
  function automatic logic word_err(input logic [SW-1:0] s, input logic [1:0] sel);
    int unsigned d;
    int unsigned t;
    logic [SW-1:0] chk;
    logic [SW-1:0] zmask;
    case (sel)
      2'd0:    begin d = 7;  t = 1; end
      2'd1:    begin d = 15; t = 1; end
      2'd2:    begin d = 23; t = 5; end
      default: begin d = 31; t = 3; end
    endcase
    chk   = s ^ (s >> (d - t)) ^ (s >> d);
    zmask = (SW'(1) << d) - SW'(1);
    return (|(chk & WMASK)) | ~(|(s & zmask));
  endfunction

  logic       en_p0;
  logic [1:0] poly_p0;
  logic       poly_chg;
  logic       chk_err_p2;

  assign poly_chg = (poly_sel_i != poly_p0);

  // stage 0: enable delay and registered polynomial copy for change detection
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      en_p0      <= 1'b0;
      poly_p0    <= 2'd0;
      chk_err_p2 <= 1'b1;
    end else begin
      en_p0      <= prbs_en_i;
      poly_p0    <= poly_sel_i;
      chk_err_p2 <= ~(&lane_lock_o);
    end
  end

  assign prbs_chk_error_o = chk_err_p2;

  for (genvar n = 0; n < NLANES; n++) begin : g_lane
    logic [30:0]      hist_p0;
    logic             err_p0;
    logic [SW-1:0]    s;
    lock_state_e      state_p1, state_d;
    logic [7:0]       crun_p1, crun_d;
    logic [7:0]       erun_p1, erun_d;
    logic [CW-1:0]    cnt_p1, cnt_d;

    assign s = {hist_p0, data_in_i[n*NBITS +: NBITS]};

    // stage 0: word check against history, history shift
    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        hist_p0 <= '0;
        err_p0  <= 1'b0;
      end else if (prbs_en_i) begin
        hist_p0 <= s[30:0];
        err_p0  <= word_err(s, poly_sel_i);
      end
    end

    always_comb begin
      state_d = state_p1;
      crun_d  = crun_p1;
      erun_d  = erun_p1;
      cnt_d   = cnt_p1;
      if (poly_chg) begin
        state_d = UNLOCKED;
        crun_d  = '0;
        erun_d  = '0;
      end else if (en_p0) begin
        if (err_p0) begin
          crun_d = '0;
          erun_d = sat_inc8(erun_p1);
          if (state_p1 == LOCKED) begin
            cnt_d = sat_inc_cnt(cnt_p1);
            if (erun_d >= LOSS_T) state_d = UNLOCKED;
          end
        end else begin
          erun_d = '0;
          crun_d = sat_inc8(crun_p1);
          if ((state_p1 == UNLOCKED) && (crun_d >= LOCK_T)) state_d = LOCKED;
        end
      end
      // a clear discards any same-cycle increment
      if (err_clr_i) cnt_d = '0;
    end

    // stage 1: lock FSM, run counters and error counter
    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        state_p1 <= UNLOCKED;
        crun_p1  <= '0;
        erun_p1  <= '0;
        cnt_p1   <= '0;
      end else begin
        state_p1 <= state_d;
        crun_p1  <= crun_d;
        erun_p1  <= erun_d;
        cnt_p1   <= cnt_d;
      end
    end

    assign lane_err_o[n]               = err_p0;
    assign lane_lock_o[n]              = (state_p1 == LOCKED);
    assign err_cnt_o[n*CW +: CW]       = cnt_p1;
  end

endmodule
